// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/NOT/XOR engine, LSB first.
// Valid/ready request and response ports; result plus zero/parity flags.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_nx;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             bit_r;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign last    = (cnt == LAST);
  assign part_nx = {bit_r, part[WIDTH-1:1]};

  always_comb begin
    bit_r = 1'b0;
    unique case (op_q)
      2'b00: bit_r = a_sh[0] & b_sh[0];
      2'b01: bit_r = a_sh[0] | b_sh[0];
      2'b10: bit_r = ~a_sh[0];
      2'b11: bit_r = a_sh[0] ^ b_sh[0];
      default: bit_r = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'b00;
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      cnt    <= '0;
      y      <= '0;
      zero   <= 1'b0;
      parity <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      a_sh <= a;
      b_sh <= b;
      part <= '0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      part <= part_nx;
      // counter saturates at the last bit; the final bit loads the outputs
      if (last) begin
        y      <= part_nx;
        zero   <= (part_nx == '0);
        parity <= ^part_nx;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Randomized and directed bench for serial_logic_unit.
// A transaction-level model predicts handshake timing and results.
module tb_serial_logic_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         zero;
  logic         parity;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [W-1:0] calc(input logic [1:0] o,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] z);
    case (o)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return ~x;
      default: return x ^ z;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cycle);
    end
  endtask

  // Transaction model: remaining shift cycles, done flag, held result.
  int           m_rem  = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_y    = '0;
  bit           m_z    = 1'b0;
  bit           m_p    = 1'b0;
  int           acc_cnt = 0;
  int           acc_cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_y    = '0;
      m_z    = 1'b0;
      m_p    = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_y    = m_pend;
        m_z    = (m_pend == 0);
        m_p    = ^m_pend;
      end
    end else if (in_valid) begin
      m_pend  = calc(op, a, b);
      m_rem   = W;
      acc_cnt++;
      acc_cyc = cycle + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready",  in_ready,  !m_done && m_rem == 0);
      chk("out_valid", out_valid, m_done);
      chk("busy",      busy,      m_done || m_rem != 0);
      chk("y",         y,         m_y);
      chk("zero",      zero,      m_z);
      chk("parity",    parity,    m_p);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] z);
    int n;
    int c0;
    n  = 0;
    c0 = acc_cnt;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = z;
    do begin
      step();
      n++;
    end while (acc_cnt == c0 && n < 100);
    in_valid = 1'b0;
    if (acc_cnt == c0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_ov(output int cyc);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    cyc = cycle;
  endtask

  task automatic run_one(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] z, input logic [W-1:0] ey,
                         input bit ez, input bit ep, input string nm);
    int c;
    out_ready = 1'b1;
    send(o, x, z);
    wait_ov(c);
    chk({nm, "_y"}, y, ey);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_parity"}, parity, ep);
    step();
  endtask

  initial begin
    int c;
    int acc1;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_parity", parity, 0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    out_ready = 1'b1;
    send(2'b00, 8'hF0, 8'h3C);
    wait_ov(c);
    chk("and_latency", c - acc_cyc, W);
    chk("and_y", y, 8'h30);
    chk("and_zero", zero, 0);
    chk("and_parity", parity, 0);
    step();

    run_one(2'b01, 8'hA5, 8'h5A, 8'hFF, 0, 0, "or");
    run_one(2'b11, 8'h01, 8'h00, 8'h01, 0, 1, "xor1");
    run_one(2'b11, 8'h55, 8'h55, 8'h00, 1, 0, "xor0");
    run_one(2'b10, 8'h0F, 8'hFF, 8'hF0, 0, 0, "not_f");
    run_one(2'b10, 8'h00, 8'h5A, 8'hFF, 0, 0, "not_0");

    // Backpressure with junk requests during SHIFT and DONE
    out_ready = 1'b0;
    acc1 = acc_cnt;
    send(2'b11, 8'h0F, 8'h33);
    in_valid = 1'b1;
    op = 2'b00;
    a = 8'hFF;
    b = 8'hFF;
    wait_ov(c);
    repeat (5) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y", y, 8'h3C);
      chk("bp_parity", parity, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_released", out_valid, 0);
    chk("bp_one_accept", acc_cnt - acc1, 1);

    // Asynchronous reset mid-SHIFT
    send(2'b00, 8'hAA, 8'hFF);
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_y", y, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_one(2'b00, 8'hFF, 8'h81, 8'h81, 0, 0, "post_rst");

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    send(2'b01, 8'h0C, 8'h30);
    acc1 = acc_cyc;
    send(2'b11, 8'hF0, 8'h0F);
    chk("b2b_spacing", acc_cyc - acc1, W + 2);
    repeat (W - 1) step();
    chk("b2b_y_hold", y, 8'h3C);
    step();
    chk("b2b_y_new", y, 8'hFF);
    chk("b2b_out_valid", out_valid, 1);
    step();

    // Randomized traffic with random backpressure and junk requests
    repeat (40) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      out_ready = 1'b0;
      send(ro, ra, rb);
      in_valid = 1'($urandom_range(0, 1));
      op = 2'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      wait_ov(c);
      chk("rnd_y", y, calc(ro, ra, rb));
      repeat ($urandom_range(0, 3)) step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
    end

    out_ready = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
